// File: rtl/mag_comp_seq.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, unsigned or two's-complement.
// Latency: 1..NCHUNK cycles from accept to out_valid (always NCHUNK when EARLY_EXIT = 0).
// Backpressure: result held in DONE until out_ready; no new operands accepted outside IDLE.
module mag_comp_seq #(
    parameter int WIDTH      = 8,
    parameter int CHUNK      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("mag_comp_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    state_t           state_q, state_d;
    opnd_t            opnd_q, opnd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [WIDTH-1:0] msb_flip;
    logic             decided;

    // Operands are shifted left each CMP cycle, so the chunk under test is always the top one.
    assign chunk_a  = opnd_q.a[WIDTH-1 -: CHUNK];
    assign chunk_b  = opnd_q.b[WIDTH-1 -: CHUNK];
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign msb_flip = signed_mode ? MSB_MASK : '0;
    assign decided  = gt_q | lt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        idx_d     = idx_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opnd_d.a = A ^ msb_flip;
                    opnd_d.b = B ^ msb_flip;
                    idx_d    = IDX_MAX;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    state_d  = CMP;
                end
            end

            CMP: begin
                busy     = 1'b1;
                opnd_d.a = opnd_q.a << CHUNK;
                opnd_d.b = opnd_q.b << CHUNK;
                // A latched decision is sticky; lower chunks only matter while still equal.
                if (!decided && (chunk_a != chunk_b)) begin
                    gt_d = (chunk_a > chunk_b);
                    lt_d = (chunk_a < chunk_b);
                    if (EARLY_EXIT != 0) begin
                        state_d = DONE;
                    end
                end
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign GT = out_valid & gt_q;
    assign LT = out_valid & lt_q;
    assign EQ = out_valid & ~gt_q & ~lt_q;

endmodule

// File: tb/tb_mag_comp_seq.sv
// Bench for mag_comp_seq (WIDTH=8, CHUNK=2): vector table, corner sequences, random traffic vs reference model.
module tb_mag_comp_seq;

    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int NCH = W / CH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         smode = 1'b0;
    logic         iv1 = 1'b0, or1 = 1'b0;
    logic         iv0 = 1'b0, or0 = 1'b0;
    logic         ir1, ov1, busy1, eq1, gt1, lt1;
    logic         ir0, ov0, busy0, eq0, gt0, lt0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mag_comp_seq #(.WIDTH(W), .CHUNK(CH), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(op_a), .B(op_b),
        .signed_mode(smode), .out_valid(ov1), .out_ready(or1), .busy(busy1),
        .EQ(eq1), .GT(gt1), .LT(lt1)
    );

    mag_comp_seq #(.WIDTH(W), .CHUNK(CH), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(op_a), .B(op_b),
        .signed_mode(smode), .out_valid(ov0), .out_ready(or0), .busy(busy0),
        .EQ(eq0), .GT(gt0), .LT(lt0)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           s;
        bit           eq;
        bit           gt;
        bit           lt;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic; latency from position of the top differing bit.
    function automatic void ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                    input bit ee, output bit eq, output bit gt, output bit lt,
                                    output int lat);
        int p;
        if (s) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        eq  = (a == b);
        lat = NCH;
        if (ee && a != b) begin
            p = W - 1;
            while (a[p] == b[p]) p--;
            lat = NCH - p / CH;
        end
    endfunction

    // {in_ready, out_valid, busy, EQ, GT, LT} of the selected instance
    function automatic logic [5:0] obs(input bit full);
        return full ? {ir0, ov0, busy0, eq0, gt0, lt0} : {ir1, ov1, busy1, eq1, gt1, lt1};
    endfunction

    task automatic run_op(input bit full, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit s, output bit eq, output bit gt, output bit lt,
                          output int lat, output bit ok);
        logic [5:0] o;
        op_a = a; op_b = b; smode = s;
        if (full) iv0 = 1'b1; else iv1 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            o = obs(full);
            if (o[5]) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        eq = 0; gt = 0; lt = 0; lat = -1;
        if (!ok) begin iv0 = 1'b0; iv1 = 1'b0; return; end
        @(posedge clk); #1;
        iv0 = 1'b0; iv1 = 1'b0;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            o = obs(full);
            if (o[4]) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        o = obs(full);
        eq = o[2]; gt = o[1]; lt = o[0];
        if (full) or0 = 1'b1; else or1 = 1'b1;
        @(posedge clk); #1;
        or0 = 1'b0; or1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit eq, gt, lt, ok;
        int lat;
        bit m_eq, m_gt, m_lt;
        int m_lat;
        logic [W-1:0] pa, pb, na, nb;

        vecs[0]  = '{8'h5A, 8'h5A, 1'b0, 1, 0, 0, 4};
        vecs[1]  = '{8'hC0, 8'hA0, 1'b0, 0, 1, 0, 1};
        vecs[2]  = '{8'h80, 8'h7F, 1'b1, 0, 0, 1, 1};
        vecs[3]  = '{8'h80, 8'h7F, 1'b0, 0, 1, 0, 1};
        vecs[4]  = '{8'hFF, 8'hFE, 1'b1, 0, 1, 0, 4};
        vecs[5]  = '{8'h00, 8'h01, 1'b0, 0, 0, 1, 4};
        vecs[6]  = '{8'h34, 8'h24, 1'b0, 0, 1, 0, 2};
        vecs[7]  = '{8'h80, 8'h80, 1'b1, 1, 0, 0, 4};
        vecs[8]  = '{8'h01, 8'hFF, 1'b1, 0, 1, 0, 1};
        vecs[9]  = '{8'hF0, 8'hF4, 1'b1, 0, 0, 1, 3};
        vecs[10] = '{8'h01, 8'hFF, 1'b0, 0, 0, 1, 1};

        // Reset state, observed while rst_n is still low
        #12;
        chk("rst_in_ready", ir1, 1);
        chk("rst_out_valid", ov1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_eqgtlt", {eq1, gt1, lt1}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].s, eq, gt, lt, lat, ok);
            chk($sformatf("vec%0d_done", i), ok, 1);
            chk($sformatf("vec%0d_eq", i), eq, vecs[i].eq);
            chk($sformatf("vec%0d_gt", i), gt, vecs[i].gt);
            chk($sformatf("vec%0d_lt", i), lt, vecs[i].lt);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            run_op(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, eq, gt, lt, lat, ok);
            chk($sformatf("vec%0d_full_res", i), {eq, gt, lt}, {vecs[i].eq, vecs[i].gt, vecs[i].lt});
            chk($sformatf("vec%0d_full_lat", i), lat, NCH);
        end

        // Back-pressure: result held, new operands ignored while DONE
        run_op(1'b0, 8'h10, 8'h20, 1'b0, eq, gt, lt, lat, ok);
        op_a = 8'h10; op_b = 8'h20; iv1 = 1'b1;
        @(posedge clk); #1;
        op_a = 8'hFF; op_b = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ov1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("bp_done", ok, 1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_valid_c%0d", c), ov1, 1);
            chk($sformatf("bp_res_c%0d", c), {eq1, gt1, lt1}, 3'b001);
            chk($sformatf("bp_in_ready_c%0d", c), ir1, 0);
            @(posedge clk); #1;
        end
        or1 = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", ir1, 1);
        chk("bp_idle_out_valid", ov1, 0);
        iv1 = 1'b0; or1 = 1'b0;

        // Reset in the middle of a compare
        op_a = 8'h5A; op_b = 8'h5A; smode = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("mid_busy_before", busy1, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_busy_async", busy1, 0);
        chk("mid_out_valid_async", ov1, 0);
        chk("mid_eqgtlt_async", {eq1, gt1, lt1}, 0);
        chk("mid_in_ready_async", ir1, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 8'hC0, 8'hA0, 1'b0, eq, gt, lt, lat, ok);
        chk("post_rst_res", {ok, eq, gt, lt}, 4'b1010);
        chk("post_rst_lat", lat, 1);

        // Back-to-back random traffic, in_valid and out_ready held high
        for (int m = 0; m < 2; m++) begin
            smode = m[0];
            pa = 8'($urandom); pb = 8'($urandom);
            op_a = pa; op_b = pb; iv1 = 1'b1; or1 = 1'b1;
            for (int n = 0; n < 20; n++) begin
                ok = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    if (ir1) begin ok = 1'b1; break; end
                    @(posedge clk); #1;
                end
                chk($sformatf("b2b_m%0d_n%0d_accept", m, n), ok, 1);
                @(posedge clk); #1;
                ref_cmp(pa, pb, m[0], 1'b1, m_eq, m_gt, m_lt, m_lat);
                na = 8'($urandom); nb = ($urandom_range(3) == 0) ? na : 8'($urandom);
                op_a = na; op_b = nb;
                if (n == 19) iv1 = 1'b0;
                lat = 0; ok = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    if (ov1) begin ok = 1'b1; break; end
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("b2b_m%0d_n%0d_res a=%0h b=%0h", m, n, pa, pb),
                    {ok, eq1, gt1, lt1}, {1'b1, m_eq, m_gt, m_lt});
                chk($sformatf("b2b_m%0d_n%0d_lat", m, n), lat, m_lat);
                chk($sformatf("b2b_m%0d_n%0d_onehot", m, n), 32'(eq1) + 32'(gt1) + 32'(lt1), 1);
                @(posedge clk); #1;
                pa = na; pb = nb;
            end
            iv1 = 1'b0; or1 = 1'b0;
            @(posedge clk); #1;
        end

        // Random pairs on the full-length instance
        for (int n = 0; n < 10; n++) begin
            pa = 8'($urandom); pb = (n % 4 == 0) ? pa : 8'($urandom);
            smode = n[0];
            ref_cmp(pa, pb, n[0], 1'b0, m_eq, m_gt, m_lt, m_lat);
            run_op(1'b1, pa, pb, n[0], eq, gt, lt, lat, ok);
            chk($sformatf("full_rnd%0d_res a=%0h b=%0h", n, pa, pb),
                {ok, eq, gt, lt}, {1'b1, m_eq, m_gt, m_lt});
            chk($sformatf("full_rnd%0d_lat", n), lat, m_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
